// File: rtl/nn_result_spi.sv
// nn_result_spi: latches the NN core's one-hot classification on each rising
// edge of done, encodes it to a digit plus error flag, and serves the result
// to an MCU as an SPI mode-0 slave frame (16 bits, MSB first).
// Optional feature macro: NN_RESULT_PARITY_EN -- appends an even-parity bit
// over the 16 frame bits, making the frame 17 bits long.
module nn_result_spi #(
   parameter int unsigned NUM_CLASSES = 10,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [0:NUM_CLASSES-1] classification,
   input  logic                   done,
   input  logic                   sck,
   input  logic                   ss_n,
   output logic                   sdo,
   output logic                   ready,
   output logic [3:0]             digit
);

`ifdef NN_RESULT_PARITY_EN
   localparam int unsigned FRAME_LEN = 17;
`else
   localparam int unsigned FRAME_LEN = 16;
`endif
   localparam int unsigned CNT_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD,
      ST_SHIFT
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;

   logic                   r_done_d;
   logic [SYNC_STAGES-1:0] r_sck_sync;
   logic [SYNC_STAGES-1:0] r_ss_sync;
   logic                   r_sck_prev;
   logic                   r_ss_prev;

   logic [15:0]            r_frame;
   logic [3:0]             r_digit;
   logic [FRAME_LEN-1:0]   r_shift;
   logic [CNT_W-1:0]       r_cnt;

   logic                   w_sck_s;
   logic                   w_ss_s;
   logic                   w_sck_rise;
   logic                   w_sck_fall;
   logic                   w_ss_rise;
   logic                   w_ss_fall;
   logic                   w_done_rise;
   logic                   w_latch;
   logic                   w_cnt_full;
   logic                   w_ready;

   logic [3:0]             w_ones;
   logic [3:0]             w_lowest;
   logic                   w_err;
   logic [15:0]            w_frame;
   logic [FRAME_LEN-1:0]   w_load_new;
   logic [FRAME_LEN-1:0]   w_load_old;

   // Synchronized SPI pins and their edge events; done is already in clk domain
   assign w_sck_s     = r_sck_sync[SYNC_STAGES-1];
   assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
   assign w_sck_rise  = w_sck_s & ~r_sck_prev;
   assign w_sck_fall  = ~w_sck_s & r_sck_prev;
   assign w_ss_rise   = w_ss_s & ~r_ss_prev;
   assign w_ss_fall   = ~w_ss_s & r_ss_prev;
   assign w_done_rise = done & ~r_done_d;
   assign w_latch     = w_done_rise && (r_state != ST_SHIFT);
   assign w_cnt_full  = (r_cnt == CNT_W'(FRAME_LEN));

   // Encode: count set bits and find the lowest set index (descending scan, last hit wins)
   always_comb begin
      w_ones   = '0;
      w_lowest = 4'hF;
      for (int unsigned i = NUM_CLASSES; i > 0; i--) begin
         if (classification[i-1]) begin
            w_lowest = 4'(i - 1);
            w_ones   = w_ones + 4'd1;
         end
      end
      w_err   = (w_ones != 4'd1);
      w_frame = {1'b1, w_err, w_lowest, classification};
   end

`ifdef NN_RESULT_PARITY_EN
   assign w_load_new = {w_frame, ^w_frame};
   assign w_load_old = {r_frame, ^r_frame};
`else
   assign w_load_new = w_frame;
   assign w_load_old = r_frame;
`endif

   // Pin synchronizers, edge-detect history and done history
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sck_sync <= '0;
         r_ss_sync  <= '1;
         r_sck_prev <= 1'b0;
         r_ss_prev  <= 1'b1;
         r_done_d   <= 1'b0;
      end else begin
         r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck};
         r_ss_sync  <= {r_ss_sync[SYNC_STAGES-2:0], ss_n};
         r_sck_prev <= w_sck_s;
         r_ss_prev  <= w_ss_s;
         r_done_d   <= done;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state and ready output
   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_latch) begin
               w_state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            w_ready = 1'b1;
            if (w_ss_fall) begin
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            w_ready = 1'b1;
            if (w_ss_rise) begin
               w_state_nxt = w_cnt_full ? ST_IDLE : ST_HOLD;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Latched result and display digit, updated only on an accepted done edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_frame <= '0;
         r_digit <= '0;
      end else if (w_latch) begin
         r_frame <= w_frame;
         r_digit <= w_lowest;
      end
   end

   // Shift register: preload on latch, shift on sck fall, reload on aborted read.
   // A completed read clears it so a later unsolicited read shifts out zeros.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shift <= '0;
      end else if (w_latch) begin
         r_shift <= w_load_new;
      end else if (r_state == ST_SHIFT) begin
         if (w_ss_rise) begin
            r_shift <= w_cnt_full ? '0 : w_load_old;
         end else if (w_sck_fall) begin
            r_shift <= {r_shift[FRAME_LEN-2:0], 1'b0};
         end
      end
   end

   // Bit counter: held at zero outside SHIFT, saturates at FRAME_LEN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (r_state != ST_SHIFT) begin
         r_cnt <= '0;
      end else if (w_sck_rise && !w_cnt_full) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign sdo   = ~w_ss_s & r_shift[FRAME_LEN-1];
   assign ready = w_ready;
   assign digit = r_digit;

endmodule
